fixed_div: RTL and testbench

Sequential signed fixed-point divider for the neuron-update datapath; computes a/b in the same sign-magnitude format as the fixed-point multiplier. The format is 1 sign bit, NUMWIDTH/2 integer bits and NUMWIDTH/2 fraction bits. It uses restoring division, one quotient bit per cycle, behind a valid/ready handshake on both sides. Overflow and precision-loss flags match the multiplier's clip_int/clip_frac semantics, so downstream clip handling is shared.

---
 rtl/fixed_div.sv | 145 ++++++++++++++
 tb/tb_fixed_div.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_div.sv
// -----------------------------------------------------------------------------
// fixed_div -- sequential signed fixed-point divider (restoring, 1 bit/cycle)
//
// Computes q = a / b in sign-magnitude fixed point: bit NUMWIDTH is the sign,
// NUMWIDTH/2 integer bits and NUMWIDTH/2 fraction bits in the magnitude.
// The dividend magnitude is pre-shifted by FRAC so the quotient keeps the same
// binary point; N = NUMWIDTH + FRAC quotient bits are produced, one per cycle.
//
// Build option: FIXED_DIV_SAT_EN -- when defined, an integer overflow
// (clip_int=1) saturates the quotient magnitude to all ones; otherwise the
// magnitude is the truncated low NUMWIDTH bits. Divide-by-zero always saturates.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a/b valid          in_ready   high only when idle
//   a, b       dividend / divisor, sign-magnitude, NUMWIDTH+1 bits
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes result
//   q          quotient, sign-magnitude (no negative zero)
//   clip_int   true quotient magnitude does not fit in NUMWIDTH bits
//   clip_frac  nonzero remainder, low-order bits lost
//   div_zero   divisor magnitude was zero
// -----------------------------------------------------------------------------
module fixed_div #(
    parameter int NUMWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUMWIDTH:0]   a,
    input  logic [NUMWIDTH:0]   b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUMWIDTH:0]   q,
    output logic                clip_int,
    output logic                clip_frac,
    output logic                div_zero
);

    localparam int FRAC = NUMWIDTH / 2;
    localparam int N    = NUMWIDTH + FRAC;
    localparam int CW   = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       count;
    logic                sign;
    logic [N-1:0]        dvd;    // dividend, consumed MSB first by shifting left
    logic [NUMWIDTH-1:0] dvs;    // divisor magnitude
    logic [NUMWIDTH-1:0] rem;    // partial remainder, always < dvs
    logic [N-1:0]        quo;    // quotient bits collected so far

    logic [NUMWIDTH:0]   rem_sh;
    logic                qbit;
    logic [NUMWIDTH-1:0] rem_nxt;
    logic [N-1:0]        quo_nxt;
    logic                clip_int_nxt;
    logic [NUMWIDTH-1:0] mag_nxt;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // One restoring-division step, plus the result formatting used on the
    // final step.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        rem_sh       = {rem, dvd[N-1]};
        qbit         = (rem_sh >= {1'b0, dvs});
        // When qbit is set the difference is < dvs, so the low NUMWIDTH bits
        // of the modular subtraction are exact.
        rem_nxt      = qbit ? (rem_sh[NUMWIDTH-1:0] - dvs) : rem_sh[NUMWIDTH-1:0];
        quo_nxt      = {quo[N-2:0], qbit};
        clip_int_nxt = |quo_nxt[N-1:NUMWIDTH];
`ifdef FIXED_DIV_SAT_EN
        mag_nxt      = clip_int_nxt ? {NUMWIDTH{1'b1}} : quo_nxt[NUMWIDTH-1:0];
`else
        mag_nxt      = quo_nxt[NUMWIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            sign      <= 1'b0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            quo       <= '0;
            q         <= '0;
            clip_int  <= 1'b0;
            clip_frac <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign  <= a[NUMWIDTH] ^ b[NUMWIDTH];
                        dvd   <= {a[NUMWIDTH-1:0], {FRAC{1'b0}}};
                        dvs   <= b[NUMWIDTH-1:0];
                        rem   <= '0;
                        quo   <= '0;
                        count <= '0;
                        if (b[NUMWIDTH-1:0] == '0) begin
                            // Magnitude is all ones, hence nonzero: sign kept.
                            q         <= {a[NUMWIDTH] ^ b[NUMWIDTH], {NUMWIDTH{1'b1}}};
                            div_zero  <= 1'b1;
                            clip_int  <= 1'b1;
                            clip_frac <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    dvd   <= dvd << 1;
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    count <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        q         <= {sign & (|mag_nxt), mag_nxt};
                        clip_int  <= clip_int_nxt;
                        clip_frac <= (rem_nxt != '0);
                        div_zero  <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_div.sv
// -----------------------------------------------------------------------------
// tb_fixed_div -- self-checking bench for fixed_div (NUMWIDTH = 16).
// Expected results are computed from integer arithmetic on the operands and
// queued when an operation is accepted; they are popped and compared when the
// DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_fixed_div;

    localparam int NW   = 16;
    localparam int FRAC = NW / 2;
    localparam int N    = NW + FRAC;
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW:0]   a;
    logic [NW:0]   b;
    logic          out_valid;
    logic          out_ready;
    logic [NW:0]   q;
    logic          clip_int;
    logic          clip_frac;
    logic          div_zero;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [NW:0] q;
        logic        ci;
        logic        cf;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fixed_div #(.NUMWIDTH(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .clip_int  (clip_int),
        .clip_frac (clip_frac),
        .div_zero  (div_zero)
    );

    function automatic exp_t model(input logic [NW:0] ai, input logic [NW:0] bi);
        exp_t e;
        longint unsigned dd, bm, qf, rm;
        logic [NW-1:0] mag;
        logic sg;
        sg = ai[NW] ^ bi[NW];
        dd = longint'(ai[NW-1:0]) << FRAC;
        bm = longint'(bi[NW-1:0]);
        if (bm == 0) begin
            e.q = {sg, {NW{1'b1}}};
            e.ci = 1'b1; e.cf = 1'b0; e.dz = 1'b1; e.lat = 0;
        end else begin
            qf = dd / bm;
            rm = dd % bm;
            e.ci = (qf >= (64'd1 << NW));
            e.cf = (rm != 0);
            e.dz = 1'b0;
            e.lat = N;
`ifdef FIXED_DIV_SAT_EN
            mag = e.ci ? {NW{1'b1}} : qf[NW-1:0];
`else
            mag = qf[NW-1:0];
`endif
            e.q = {sg & (mag != 0), mag};
        end
        return e;
    endfunction

    // Drive one operation; returns just after the accept edge (at the next
    // negedge) with in_valid dropped and operands scrambled.
    task automatic issue(input logic [NW:0] ai, input logic [NW:0] bi);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1; a = ai; b = bi;
        while (!in_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (!in_ready) begin
            failed++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        sb.push_back(model(ai, bi));
        @(negedge clk);
        in_valid = 1'b0;
        a = 17'($urandom);
        b = 17'($urandom);
    endtask

    // Wait for out_valid from the current negedge, check latency and results.
    // When take is 0 the result is left pending.
    task automatic collect(input string name, input bit take);
        int   k = 0;
        exp_t e;
        while (!out_valid && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() == 0) begin
            tests++; failed++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        tests++;
        if (!out_valid) begin
            failed++;
            $display("FAIL %s_timeout: out_valid never rose", name);
            return;
        end
        tests++;
        if (k !== e.lat) begin
            failed++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, k, e.lat);
        end
        tests++;
        if ({q, clip_int, clip_frac, div_zero} !== {e.q, e.ci, e.cf, e.dz}) begin
            failed++;
            $display("FAIL %s_result: q=%h ci=%b cf=%b dz=%b, required q=%h ci=%b cf=%b dz=%b",
                     name, q, clip_int, clip_frac, div_zero, e.q, e.ci, e.cf, e.dz);
        end
        if (take) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failed++;
                $display("FAIL %s_take: in_ready=%b out_valid=%b, required 1/0",
                         name, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({in_ready, out_valid, q, clip_int, clip_frac, div_zero} !== {1'b1, 1'b0, 17'h0, 3'b000}) begin
            failed++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h flags=%b%b%b, required 1/0/00000/000",
                     in_ready, out_valid, q, clip_int, clip_frac, div_zero);
        end
    endtask

    task automatic test_vectors();
        issue(17'h00200, 17'h00080); collect("two_by_half", 1'b1);
        issue(17'h10300, 17'h00200); collect("neg3_by_2", 1'b1);
        issue(17'h00100, 17'h00300); collect("one_by_three", 1'b1);
        issue(17'h0C800, 17'h00001); collect("overflow", 1'b1);
        issue(17'h1FFFF, 17'h0FFFF); collect("max_by_max", 1'b1);
        issue(17'h10000, 17'h00123); collect("zero_dividend", 1'b1);
    endtask

    task automatic test_div_zero();
        issue(17'h10100, 17'h10000); collect("div_zero", 1'b1);
        issue(17'h00100, 17'h10000); collect("div_zero_neg", 1'b1);
    endtask

    task automatic test_backpressure();
        logic [NW+3:0] snap;
        bit bad = 1'b0;
        issue(17'h10300, 17'h00200);
        collect("bp_first", 1'b0);
        snap = {q, clip_int, clip_frac, div_zero};
        repeat (10) begin
            @(negedge clk);
            if ({q, clip_int, clip_frac, div_zero} !== snap || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad = 1'b1;
        end
        tests++;
        if (bad) begin
            failed++;
            $display("FAIL backpressure_hold: q=%h in_ready=%b out_valid=%b, required q=%h 0/1",
                     q, in_ready, out_valid, snap[NW+3:3]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_calc();
        bit seen = 1'b0;
        issue(17'h00200, 17'h00080);
        void'(sb.pop_back());   // this operation is dropped by reset
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({in_ready, out_valid, q, clip_int, clip_frac, div_zero} !== {1'b1, 1'b0, 17'h0, 3'b000}) begin
            failed++;
            $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b q=%h flags=%b%b%b, required 1/0/00000/000",
                     in_ready, out_valid, q, clip_int, clip_frac, div_zero);
        end
        repeat (N + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            failed++;
            $display("FAIL reset_dropped: out_valid=1 seen, required 0");
        end
        issue(17'h00100, 17'h00300); collect("after_reset", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [NW:0] ra, rb;
        for (int i = 0; i < 20; i++) begin
            ra = 17'($urandom);
            rb = 17'($urandom);
            if (i % 4 == 1) rb[NW-1:0] = 16'($urandom_range(1, 15));
            if (i % 7 == 3) rb[NW-1:0] = '0;
            issue(ra, rb);
            collect("random", 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
